// File: rtl/branch_predictor_btb.sv
// Branch target buffer with 2-bit saturating direction counters, combinational
// IF-stage lookup, MEM-stage update, mispredict detection and saturating statistics.
module branch_predictor_btb #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             Rst,
  input  logic [31:0]      I_PC,
  output logic             Pred_Taken,
  output logic [31:0]      Pred_NPC,
  input  logic             Upd_EN,
  input  logic [31:0]      Upd_PC,
  input  logic             Upd_IsJump,
  input  logic             Upd_Taken,
  input  logic [31:0]      Upd_Target,
  input  logic             Upd_PredTaken,
  input  logic [31:0]      Upd_PredNPC,
  output logic             Mispredict,
  output logic [31:0]      Correct_PC,
  output logic [CNT_W-1:0] Br_Count,
  output logic [CNT_W-1:0] Mis_Count
);
  localparam int TAG_W = 30 - IDX_W;

  logic             r_valid [ENTRIES];
  logic [1:0]       r_ctr   [ENTRIES];
  logic [TAG_W-1:0] r_tag   [ENTRIES];
  logic [31:0]      r_tgt   [ENTRIES];
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mis_cnt;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  function automatic logic [CNT_W-1:0] stat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Lookup: zero-latency, sees only state committed at earlier edges
  logic [IDX_W-1:0] w_l_idx;
  logic [TAG_W-1:0] w_l_tag;
  logic             w_l_hit;

  assign w_l_idx    = I_PC[2 +: IDX_W];
  assign w_l_tag    = I_PC[31 -: TAG_W];
  assign w_l_hit    = r_valid[w_l_idx] && (r_tag[w_l_idx] == w_l_tag);
  assign Pred_Taken = w_l_hit && r_ctr[w_l_idx][1];
  assign Pred_NPC   = Pred_Taken ? r_tgt[w_l_idx] : I_PC + 32'd4;

  // Resolution: full next-PC compare covers wrong direction and wrong target
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic             w_alloc;
  logic             w_hit_upd;
  logic             w_tgt_wr;
  logic [31:0]      w_actual_npc;
  logic [1:0]       w_ctr_nxt;

  assign w_u_idx      = Upd_PC[2 +: IDX_W];
  assign w_u_tag      = Upd_PC[31 -: TAG_W];
  assign w_u_hit      = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_alloc      = Upd_EN && !w_u_hit && Upd_Taken;
  assign w_hit_upd    = Upd_EN && w_u_hit;
  assign w_tgt_wr     = w_alloc || (w_hit_upd && Upd_Taken);
  assign w_actual_npc = Upd_Taken ? Upd_Target : Upd_PC + 32'd4;
  assign Correct_PC   = w_actual_npc;
  assign Mispredict   = Upd_EN && (w_actual_npc != Upd_PredNPC);
  assign Br_Count     = r_br_cnt;
  assign Mis_Count    = r_mis_cnt;

  always_comb begin
    w_ctr_nxt = r_ctr[w_u_idx];
    if (w_alloc)
      w_ctr_nxt = Upd_IsJump ? 2'd3 : 2'd2;
    else if (Upd_IsJump)
      w_ctr_nxt = 2'd3;
    else if (Upd_Taken)
      w_ctr_nxt = ctr_inc(r_ctr[w_u_idx]);
    else
      w_ctr_nxt = ctr_dec(r_ctr[w_u_idx]);
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'd1;
      end
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (Upd_EN) begin
      r_br_cnt <= stat_inc(r_br_cnt);
      if (Mispredict)
        r_mis_cnt <= stat_inc(r_mis_cnt);
      if (w_alloc)
        r_valid[w_u_idx] <= 1'b1;
      if (w_alloc || w_hit_upd)
        r_ctr[w_u_idx] <= w_ctr_nxt;
    end
  end

  // Tag/target storage is gated by valid everywhere, so it carries no reset
  always_ff @(posedge CLK) begin
    if (w_alloc)
      r_tag[w_u_idx] <= w_u_tag;
    if (w_tgt_wr)
      r_tgt[w_u_idx] <= Upd_Target;
  end

  // A not-taken prediction must have carried the fall-through PC down the pipe
  always_ff @(posedge CLK) begin
    if (!Rst && Upd_EN && !Upd_PredTaken)
      assert (Upd_PredNPC == Upd_PC + 32'd4);
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: hand-derived vector table, corner sequences and
// random traffic against an array-based reference model; a CNT_W=2 twin checks saturation.
module tb_branch_predictor_btb;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ipc;
  logic        en;
  logic [31:0] upc;
  logic        jmp;
  logic        tkn;
  logic [31:0] tgt;
  logic        ppt;
  logic [31:0] pnpc;

  logic        pt, mp, pt2, mp2;
  logic [31:0] npc, cpc, npc2, cpc2;
  logic [15:0] br, mc;
  logic [1:0]  br2, mc2;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  branch_predictor_btb #(.ENTRIES(16), .CNT_W(16)) dut (
    .CLK(clk), .Rst(rst), .I_PC(ipc), .Pred_Taken(pt), .Pred_NPC(npc),
    .Upd_EN(en), .Upd_PC(upc), .Upd_IsJump(jmp), .Upd_Taken(tkn),
    .Upd_Target(tgt), .Upd_PredTaken(ppt), .Upd_PredNPC(pnpc),
    .Mispredict(mp), .Correct_PC(cpc), .Br_Count(br), .Mis_Count(mc)
  );

  branch_predictor_btb #(.ENTRIES(16), .CNT_W(2)) dut2 (
    .CLK(clk), .Rst(rst), .I_PC(ipc), .Pred_Taken(pt2), .Pred_NPC(npc2),
    .Upd_EN(en), .Upd_PC(upc), .Upd_IsJump(jmp), .Upd_Taken(tkn),
    .Upd_Target(tgt), .Upd_PredTaken(ppt), .Upd_PredNPC(pnpc),
    .Mispredict(mp2), .Correct_PC(cpc2), .Br_Count(br2), .Mis_Count(mc2)
  );

  // Reference model: one record per index, counters kept as plain integers
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_br, m_mc;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic void m_look(input logic [31:0] pc, output bit t, output logic [31:0] n);
    int  i;
    bit  hit;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == (pc >> 6));
    t   = hit && (m_ctr[i] >= 2);
    n   = t ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic m_edge();
    int i;
    logic [31:0] act;
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 0;
        m_ctr[k]   = 1;
      end
      m_br = 0;
      m_mc = 0;
    end else if (en) begin
      i   = idx_of(upc);
      act = tkn ? tgt : upc + 32'd4;
      m_br++;
      if (act != pnpc) m_mc++;
      if (m_valid[i] && m_tag[i] == (upc >> 6)) begin
        if (jmp) m_ctr[i] = 3;
        else if (tkn) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        else m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        if (tkn) m_tgt[i] = tgt;
      end else if (tkn) begin
        m_valid[i] = 1;
        m_tag[i]   = upc >> 6;
        m_tgt[i]   = tgt;
        m_ctr[i]   = jmp ? 3 : 2;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit          et;
    logic [31:0] en_pc, ecpc;
    m_look(ipc, et, en_pc);
    ecpc = tkn ? tgt : upc + 32'd4;
    check("pred_taken", {31'd0, pt}, {31'd0, et});
    check("pred_npc", npc, en_pc);
    check("mispredict", {31'd0, mp}, {31'd0, en && (ecpc != pnpc)});
    check("correct_pc", cpc, ecpc);
    check("br_count", {16'd0, br}, sat(m_br, 65535));
    check("mis_count", {16'd0, mc}, sat(m_mc, 65535));
    check("pred_npc_w2", npc2, en_pc);
    check("br_count_w2", {30'd0, br2}, sat(m_br, 3));
    check("mis_count_w2", {30'd0, mc2}, sat(m_mc, 3));
  endtask

  // Compare at the falling edge, commit model at the rising edge
  task automatic cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] ipc;
    logic        en;
    logic [31:0] upc;
    logic        jmp, tkn;
    logic [31:0] tgt;
    logic        ppt;
    logic [31:0] pnpc;
    logic        e_pt;
    logic [31:0] e_npc;
    logic        e_mp;
    logic [31:0] e_cpc;
    int          e_br, e_mc;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input logic r, input logic [31:0] ip, input logic e,
                              input logic [31:0] up, input logic j, input logic t,
                              input logic [31:0] tg, input logic pp, input logic [31:0] pn,
                              input logic ept, input logic [31:0] enpc, input logic emp,
                              input logic [31:0] ecpc, input int ebr, input int emc);
    vec_t v;
    v.rst = r; v.ipc = ip; v.en = e; v.upc = up; v.jmp = j; v.tkn = t; v.tgt = tg;
    v.ppt = pp; v.pnpc = pn; v.e_pt = ept; v.e_npc = enpc; v.e_mp = emp;
    v.e_cpc = ecpc; v.e_br = ebr; v.e_mc = emc;
    return v;
  endfunction

  task automatic idle_inputs(input logic [31:0] lookup_pc);
    rst = 0; ipc = lookup_pc; en = 0; upc = 0; jmp = 0; tkn = 0; tgt = 0; ppt = 0; pnpc = 0;
  endtask

  initial begin
    bit          rt;
    logic [31:0] rn;

    idle_inputs(32'h0040_0010);
    rst = 1;
    @(posedge clk); m_edge(); #1;
    @(posedge clk); m_edge(); #1;
    rst = 0;

    //       rst ipc           en upc           j  t  tgt           pt pnpc          | ept enpc          emp ecpc          br  mc
    tab.push_back(mk(0, 32'h00400010, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h00400014, 0, 32'h4,        0, 0));
    tab.push_back(mk(0, 32'h00400010, 1, 32'h00400010, 0, 1, 32'h00400000, 0, 32'h00400014, 0, 32'h00400014, 1, 32'h00400000, 0, 0));
    tab.push_back(mk(0, 32'h00400010, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h00400000, 0, 32'h4,        1, 1));
    tab.push_back(mk(0, 32'h00400010, 1, 32'h00400010, 0, 0, 32'h0,        1, 32'h00400000, 1, 32'h00400000, 1, 32'h00400014, 1, 1));
    tab.push_back(mk(0, 32'h00400010, 1, 32'h00400010, 0, 0, 32'h0,        0, 32'h00400014, 0, 32'h00400014, 0, 32'h00400014, 2, 2));
    tab.push_back(mk(0, 32'h00400010, 1, 32'h00400010, 0, 1, 32'h00400000, 0, 32'h00400014, 0, 32'h00400014, 1, 32'h00400000, 3, 2));
    tab.push_back(mk(0, 32'h00400010, 1, 32'h00400010, 0, 1, 32'h00400000, 0, 32'h00400014, 0, 32'h00400014, 1, 32'h00400000, 4, 3));
    tab.push_back(mk(0, 32'h00400010, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h00400000, 0, 32'h4,        5, 4));
    tab.push_back(mk(0, 32'h00400010, 1, 32'h00400050, 0, 1, 32'h00400100, 0, 32'h00400054, 1, 32'h00400000, 1, 32'h00400100, 5, 4));
    tab.push_back(mk(0, 32'h00400010, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h00400014, 0, 32'h4,        6, 5));
    tab.push_back(mk(0, 32'h00400050, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h00400100, 0, 32'h4,        6, 5));
    tab.push_back(mk(0, 32'h00400050, 1, 32'h00400090, 0, 0, 32'h0,        0, 32'h00400094, 1, 32'h00400100, 0, 32'h00400094, 6, 5));
    tab.push_back(mk(0, 32'h00400050, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h00400100, 0, 32'h4,        7, 5));
    tab.push_back(mk(0, 32'h00400020, 1, 32'h00400020, 0, 1, 32'h00400200, 0, 32'h00400024, 0, 32'h00400024, 1, 32'h00400200, 7, 5));
    tab.push_back(mk(0, 32'h00400020, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h00400200, 0, 32'h4,        8, 6));
    tab.push_back(mk(0, 32'h00400020, 1, 32'h00400020, 0, 0, 32'h0,        1, 32'h00400200, 1, 32'h00400200, 1, 32'h00400024, 8, 6));
    tab.push_back(mk(0, 32'h00400020, 1, 32'h00400020, 0, 0, 32'h0,        0, 32'h00400024, 0, 32'h00400024, 0, 32'h00400024, 9, 7));
    tab.push_back(mk(0, 32'h00400020, 1, 32'h00400020, 1, 1, 32'h00400300, 0, 32'h00400024, 0, 32'h00400024, 1, 32'h00400300, 10, 7));
    tab.push_back(mk(0, 32'h00400020, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h00400300, 0, 32'h4,        11, 8));
    tab.push_back(mk(0, 32'h00400020, 1, 32'h00400020, 0, 0, 32'h0,        1, 32'h00400300, 1, 32'h00400300, 1, 32'h00400024, 11, 8));
    tab.push_back(mk(0, 32'h00400020, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h00400300, 0, 32'h4,        12, 9));
    tab.push_back(mk(1, 32'h00400040, 1, 32'h00400040, 0, 1, 32'h00400400, 0, 32'h00400044, 0, 32'h00400044, 1, 32'h00400400, 12, 9));
    tab.push_back(mk(0, 32'h00400040, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h00400044, 0, 32'h4,        0, 0));
    tab.push_back(mk(0, 32'h00400020, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h00400024, 0, 32'h4,        0, 0));
    tab.push_back(mk(0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0));
    tab.push_back(mk(0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 1, 32'h00000100, 0, 32'h0,        0, 32'h0,        1, 32'h00000100, 1, 0));
    tab.push_back(mk(0, 32'hFFFFFFFC, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h00000100, 0, 32'h4,        2, 1));
    tab.push_back(mk(0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 1, 32'h00000200, 1, 32'h00000100, 1, 32'h00000100, 1, 32'h00000200, 2, 1));
    tab.push_back(mk(0, 32'hFFFFFFFC, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h00000200, 0, 32'h4,        3, 2));
    tab.push_back(mk(0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 1, 32'h00000200, 1, 32'h00000200, 1, 32'h00000200, 0, 32'h00000200, 3, 2));

    foreach (tab[k]) begin
      rst = tab[k].rst; ipc = tab[k].ipc; en = tab[k].en; upc = tab[k].upc;
      jmp = tab[k].jmp; tkn = tab[k].tkn; tgt = tab[k].tgt; ppt = tab[k].ppt;
      pnpc = tab[k].pnpc;
      @(negedge clk);
      check($sformatf("tab%0d_pt", k), {31'd0, pt}, {31'd0, tab[k].e_pt});
      check($sformatf("tab%0d_npc", k), npc, tab[k].e_npc);
      check($sformatf("tab%0d_mp", k), {31'd0, mp}, {31'd0, tab[k].e_mp});
      check($sformatf("tab%0d_cpc", k), cpc, tab[k].e_cpc);
      check($sformatf("tab%0d_br", k), {16'd0, br}, tab[k].e_br);
      check($sformatf("tab%0d_mc", k), {16'd0, mc}, tab[k].e_mc);
      check_model();
      @(posedge clk);
      m_edge();
      #1;
    end

    // Five mispredicted updates on a 2-bit statistics counter
    idle_inputs(32'h00400100);
    rst = 1;
    cycle();
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      en = 1; upc = 32'h00400100 + 32'(k * 4); tkn = 1; tgt = 32'h00401000;
      ppt = 0; pnpc = upc + 32'd4;
      cycle();
    end
    idle_inputs(32'h00400100);
    @(negedge clk);
    check("sat_br_w2", {30'd0, br2}, 32'd3);
    check("sat_mc_w2", {30'd0, mc2}, 32'd3);
    check("sat_br_w16", {16'd0, br}, 32'd5);
    check("sat_mc_w16", {16'd0, mc}, 32'd5);
    @(posedge clk); m_edge(); #1;

    // Random traffic over a small PC pool so hits, aliases and saturation all occur
    for (int k = 0; k < 400; k++) begin
      rst  = ($urandom_range(0, 49) == 0);
      ipc  = 32'h00400000 + (32'($urandom_range(0, 63)) << 2);
      en   = ($urandom_range(0, 3) != 0);
      upc  = 32'h00400000 + (32'($urandom_range(0, 63)) << 2);
      jmp  = ($urandom_range(0, 4) == 0);
      tkn  = jmp ? 1'b1 : 1'($urandom_range(0, 1));
      tgt  = 32'h00400000 + (32'($urandom_range(0, 7)) << 4);
      m_look(upc, rt, rn);
      ppt  = rt;
      pnpc = (rt && $urandom_range(0, 3) == 0) ? 32'h00500000 : rn;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
